// File: rtl/conv_pe_stream_if.sv
// Streaming sample input (valid/ready) and result output (valid/last, no backpressure)
// of the convolution PE. Signal names are from the PE's point of view.
interface conv_pe_stream_if #(
    parameter int unsigned DATA_W = 30,
    parameter int unsigned ACC_W  = 48
);
    logic signed [DATA_W-1:0] i_data;
    logic                     i_valid;
    logic                     o_ready;
    logic signed [ACC_W-1:0]  o_data;
    logic                     o_valid;
    logic                     o_last;

    modport master (
        output i_data,
        output i_valid,
        input  o_ready,
        input  o_data,
        input  o_valid,
        input  o_last
    );

    modport slave (
        input  i_data,
        input  i_valid,
        output o_ready,
        output o_data,
        output o_valid,
        output o_last
    );
endinterface

// File: rtl/conv_pe_stream.sv
// KxK single-channel 2D convolution PE over a raster-streamed NxN map with internal
// zero padding, stride-aware output selection and a bubble-tolerant input handshake.
module conv_pe_stream #(
    parameter int unsigned DATA_W      = 30,
    parameter int unsigned WEIGHT_W    = 18,
    parameter int unsigned ACC_W       = 48,
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned FM_SIZE     = 5,
    parameter int unsigned PADDING     = 0,
    parameter int unsigned STRIDE      = 1
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst,
    input  logic                                          i_start,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*WEIGHT_W-1:0]   i_weight,
    output logic                                          o_busy,
    conv_pe_stream_if.slave                               s_if
);
    localparam int K        = int'(KERNEL_SIZE);
    localparam int P        = int'(PADDING);
    localparam int N        = int'(FM_SIZE);
    localparam int S        = int'(STRIDE);
    localparam int H        = N + 2 * P;
    localparam int OUT      = (H - K) / S + 1;
    localparam int RLastWin = K - 1 + (OUT - 1) * S;
    localparam int CntW     = $clog2(H + 1);
    localparam int IdxW     = (H > 1) ? $clog2(H) : 1;
    localparam int PW       = int'(DATA_W + WEIGHT_W);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                     state_q, state_d;
    logic [CntW-1:0]            r_q, r_d, c_q, c_d;
    logic signed [DATA_W-1:0]   win_q    [K][K];
    logic signed [DATA_W-1:0]   win_d    [K][K];
    logic signed [WEIGHT_W-1:0] weight_q [K][K];
    logic signed [WEIGHT_W-1:0] weight_d [K][K];
    logic                       win_valid_q, win_valid_d;
    logic                       win_last_q, win_last_d;
    logic                       o_valid_q, o_valid_d;
    logic                       o_last_q, o_last_d;
    logic signed [ACC_W-1:0]    o_data_q, o_data_d;

    logic                       pad, adv, ready;
    logic signed [DATA_W-1:0]   x;
    logic signed [DATA_W-1:0]   col [K];
    logic [IdxW-1:0]            col_idx;
    int                         r_i, c_i;
    logic                       win_ok;

    assign col_idx = c_q[IdxW-1:0];

    // Line buffer j holds row r-1-j at every column; col[K-1] is the incoming sample.
    if (K > 1) begin : g_lb
        logic signed [DATA_W-1:0] lb_q [K-1][H];

        always_ff @(posedge i_clk) begin
            if (adv) begin
                lb_q[0][col_idx] <= x;
                for (int j = 1; j < K - 1; j++) begin
                    lb_q[j][col_idx] <= lb_q[j-1][col_idx];
                end
            end
        end

        always_comb begin
            col[K-1] = x;
            for (int j = 0; j < K - 1; j++) begin
                col[K-2-j] = lb_q[j][col_idx];
            end
        end
    end else begin : g_no_lb
        always_comb col[0] = x;
    end

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        c_d      = c_q;
        weight_d = weight_q;
        win_d    = win_q;
        adv      = 1'b0;
        ready    = 1'b0;
        r_i      = 32'(r_q);
        c_i      = 32'(c_q);
        pad      = (r_i < P) || (r_i >= P + N) || (c_i < P) || (c_i >= P + N);
        x        = pad ? '0 : s_if.i_data;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = StRun;
                    r_d     = '0;
                    c_d     = '0;
                    for (int i = 0; i < K; i++) begin
                        for (int j = 0; j < K; j++) begin
                            weight_d[i][j] = i_weight[(i*K+j)*int'(WEIGHT_W) +: WEIGHT_W];
                        end
                    end
                end
            end
            StRun: begin
                ready = ~pad;
                adv   = pad | s_if.i_valid;
                if (adv) begin
                    if (c_i == H - 1) begin
                        c_d = '0;
                        if (r_i == H - 1) begin
                            state_d = StDrain;
                        end else begin
                            r_d = r_q + 1'b1;
                        end
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                // Leave once the window stage is empty; the output stage is then emitting.
                if (!win_valid_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (adv) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) begin
                    win_d[i][j] = win_q[i][j+1];
                end
                win_d[i][K-1] = col[i];
            end
        end

        win_ok = (r_i >= K - 1) && (c_i >= K - 1) &&
                 ((r_i - (K - 1)) % S == 0) && ((c_i - (K - 1)) % S == 0);
        win_valid_d = adv && win_ok;
        win_last_d  = adv && win_ok && (r_i == RLastWin) && (c_i == RLastWin);
    end

    // Full-width signed products, sign-extended and summed modulo 2^ACC_W.
    always_comb begin
        logic signed [ACC_W-1:0] acc;
        logic signed [PW-1:0]    prod;
        acc  = '0;
        prod = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                prod = PW'(win_q[i][j]) * PW'(weight_q[i][j]);
                acc  = acc + ACC_W'(prod);
            end
        end
        o_data_d  = win_valid_q ? acc : o_data_q;
        o_valid_d = win_valid_q;
        o_last_d  = win_last_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            r_q         <= '0;
            c_q         <= '0;
            win_q       <= '{default: '0};
            weight_q    <= '{default: '0};
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            o_valid_q   <= 1'b0;
            o_last_q    <= 1'b0;
            o_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            c_q         <= c_d;
            win_q       <= win_d;
            weight_q    <= weight_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            o_valid_q   <= o_valid_d;
            o_last_q    <= o_last_d;
            o_data_q    <= o_data_d;
        end
    end

    assign s_if.o_ready = ready;
    assign s_if.o_data  = o_data_q;
    assign s_if.o_valid = o_valid_q;
    assign s_if.o_last  = o_last_q;
    assign o_busy       = (state_q != StIdle);
endmodule

// File: tb/tb_conv_pe_stream.sv
// Directed bench for conv_pe_stream: four configurations share one stimulus bus,
// results are checked against hand-computed tables plus latency/handshake sequences.
module tb_conv_pe_stream;
    typedef struct {
        int     scen;
        longint exp;
        bit     last;
    } vec_t;

    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    int                  sel;
    logic                s_start;
    logic signed [29:0]  s_data;
    logic                s_valid;
    logic [161:0]        s_weight;
    logic [31:0]         w_d = {4{8'h80}};
    logic                busy_a, busy_b, busy_c, busy_d;

    conv_pe_stream_if #(.DATA_W(30), .ACC_W(48)) if_a ();
    conv_pe_stream_if #(.DATA_W(30), .ACC_W(48)) if_b ();
    conv_pe_stream_if #(.DATA_W(30), .ACC_W(48)) if_c ();
    conv_pe_stream_if #(.DATA_W(8),  .ACC_W(16)) if_d ();

    assign if_a.i_data  = s_data;
    assign if_b.i_data  = s_data;
    assign if_c.i_data  = s_data;
    assign if_d.i_data  = s_data[7:0];
    assign if_a.i_valid = s_valid && (sel == 0);
    assign if_b.i_valid = s_valid && (sel == 1);
    assign if_c.i_valid = s_valid && (sel == 2);
    assign if_d.i_valid = s_valid && (sel == 3);

    conv_pe_stream #(.PADDING(0), .STRIDE(1)) u_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(s_start && (sel == 0)),
        .i_weight(s_weight), .o_busy(busy_a), .s_if(if_a)
    );
    conv_pe_stream #(.PADDING(1), .STRIDE(1)) u_b (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(s_start && (sel == 1)),
        .i_weight(s_weight), .o_busy(busy_b), .s_if(if_b)
    );
    conv_pe_stream #(.PADDING(0), .STRIDE(2)) u_c (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(s_start && (sel == 2)),
        .i_weight(s_weight), .o_busy(busy_c), .s_if(if_c)
    );
    conv_pe_stream #(
        .DATA_W(8), .WEIGHT_W(8), .ACC_W(16), .KERNEL_SIZE(2), .FM_SIZE(2)
    ) u_d (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(s_start && (sel == 3)),
        .i_weight(w_d), .o_busy(busy_d), .s_if(if_d)
    );

    logic   m_ready, m_valid, m_last, m_busy;
    longint m_data;

    always_comb begin
        m_ready = 1'b0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_busy  = 1'b0;
        m_data  = 0;
        case (sel)
            0: begin
                m_ready = if_a.o_ready; m_valid = if_a.o_valid; m_last = if_a.o_last;
                m_busy = busy_a; m_data = 64'(if_a.o_data);
            end
            1: begin
                m_ready = if_b.o_ready; m_valid = if_b.o_valid; m_last = if_b.o_last;
                m_busy = busy_b; m_data = 64'(if_b.o_data);
            end
            2: begin
                m_ready = if_c.o_ready; m_valid = if_c.o_valid; m_last = if_c.o_last;
                m_busy = busy_c; m_data = 64'(if_c.o_data);
            end
            default: begin
                m_ready = if_d.o_ready; m_valid = if_d.o_valid; m_last = if_d.o_last;
                m_busy = busy_d; m_data = 64'(if_d.o_data);
            end
        endcase
    end

    int     cyc = 0;
    longint got_data[$];
    bit     got_last[$];
    int     got_cyc[$];
    int     acc_cyc[$];
    int     pre_low;
    bit     prev_last;
    int     busy_at_last, busy_after_last;
    int     nvec = 0, nmis = 0;
    vec_t   tbl[$];

    longint exp_a[9]  = '{63, 72, 81, 108, 117, 126, 153, 162, 171};
    longint exp_b[25] = '{16, 27, 33, 39, 28,   39, 63, 72, 81, 57,   69, 108, 117, 126, 87,
                          99, 153, 162, 171, 117,   76, 117, 123, 129, 88};
    longint exp_c[4]  = '{63, 81, 153, 171};
    // Weights 1..9 row-major over data 1..25: 411 at the origin, +45 per column, +225 per row.
    longint exp_w[9]  = '{411, 456, 501, 636, 681, 726, 861, 906, 951};

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    initial begin
        prev_last = 1'b0;
        forever begin
            @(negedge i_clk);
            if (m_valid) begin
                got_data.push_back(m_data);
                got_last.push_back(m_last);
                got_cyc.push_back(cyc);
            end
            if (prev_last) busy_after_last = int'(m_busy);
            if (m_valid && m_last) busy_at_last = int'(m_busy);
            prev_last = m_valid && m_last;
            if (s_valid && m_ready) acc_cyc.push_back(cyc);
            else if (m_busy && !m_ready && acc_cyc.size() == 0) pre_low++;
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        nvec++;
        if (got != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic clear_mon();
        got_data.delete();
        got_last.delete();
        got_cyc.delete();
        acc_cyc.delete();
        pre_low         = 0;
        busy_at_last    = -1;
        busy_after_last = -1;
    endtask

    task automatic set_weights(input bit ramp);
        for (int i = 0; i < 9; i++) s_weight[i*18 +: 18] = ramp ? 18'(i + 1) : 18'd1;
    endtask

    task automatic start_frame(input int d);
        clear_mon();
        sel = d;
        @(posedge i_clk); #1 s_start = 1'b1;
        @(posedge i_clk); #1 s_start = 1'b0;
    endtask

    // Feeds samples until n are accepted (or the cycle budget expires), then waits for idle.
    task automatic run_frame(input int d, input int bubble, input bit neg, input int n);
        int k = 0;
        int t = 0;
        start_frame(d);
        while (k < n && t < 400) begin
            s_data  = neg ? -30'sd128 : 30'(k + 1);
            s_valid = ($urandom_range(99) >= bubble);
            @(negedge i_clk);
            if (s_valid && m_ready) k++;
            @(posedge i_clk); #1;
            t++;
        end
        s_valid = 1'b0;
        t = 0;
        while (m_busy && t < 100) begin
            @(posedge i_clk); #1;
            t++;
        end
        @(negedge i_clk); #1;
        chk($sformatf("sel%0d_frame_complete", d), longint'(k == n && !m_busy), 1);
    endtask

    task automatic check_frame(input int s);
        int k = 0;
        foreach (tbl[i]) begin
            if (tbl[i].scen == s) begin
                if (k < got_data.size()) begin
                    chk($sformatf("s%0d_out%0d_data", s, k), got_data[k], tbl[i].exp);
                    chk($sformatf("s%0d_out%0d_last", s, k), longint'(got_last[k]),
                        longint'(tbl[i].last));
                end
                k++;
            end
        end
        chk($sformatf("s%0d_out_count", s), got_data.size(), k);
        chk($sformatf("s%0d_busy_with_last", s), busy_at_last, 1);
        chk($sformatf("s%0d_busy_after_last", s), busy_after_last, 0);
    endtask

    // Unpadded case: output (i,j) completes at accept (i*S+K-1)*N + j*S+K-1.
    task automatic check_latency(input int kk, input int nn, input int ss, input int outn);
        for (int k = 0; k < got_cyc.size(); k++) begin
            int idx;
            idx = ((k / outn) * ss + kk - 1) * nn + (k % outn) * ss + kk - 1;
            if (idx < acc_cyc.size())
                chk($sformatf("latency_out%0d", k), longint'(got_cyc[k] - acc_cyc[idx]), 2);
            else
                chk($sformatf("latency_out%0d_accept_seen", k), 0, 1);
        end
    endtask

    function automatic void add(input int s, input longint v, input bit last);
        vec_t e;
        e.scen = s;
        e.exp  = v;
        e.last = last;
        tbl.push_back(e);
    endfunction

    initial begin
        int k;
        int t;
        foreach (exp_a[i]) add(0, exp_a[i], i == 8);
        foreach (exp_b[i]) add(1, exp_b[i], i == 24);
        foreach (exp_c[i]) add(2, exp_c[i], i == 3);
        add(3, 0, 1'b1);
        foreach (exp_w[i]) add(4, exp_w[i], i == 8);

        sel = 0; s_start = 1'b0; s_valid = 1'b0; s_data = '0;
        set_weights(1'b0);
        clear_mon();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_o_data", m_data, 0);
        chk("reset_o_valid", longint'(m_valid), 0);
        chk("reset_o_last", longint'(m_last), 0);
        chk("reset_o_ready", longint'(m_ready), 0);
        chk("reset_o_busy", longint'(m_busy), 0);
        i_rst = 1'b0;

        run_frame(0, 0, 1'b0, 25);
        check_frame(0);
        check_latency(3, 5, 1, 3);

        run_frame(0, 50, 1'b0, 25);
        check_frame(0);
        check_latency(3, 5, 1, 3);

        set_weights(1'b1);
        run_frame(0, 30, 1'b0, 25);
        check_frame(4);
        check_latency(3, 5, 1, 3);

        set_weights(1'b0);
        run_frame(1, 0, 1'b0, 25);
        check_frame(1);
        // Seven top-row pads plus the left pad of row 1.
        chk("pad_ready_low_cycles", pre_low, 8);

        run_frame(2, 0, 1'b0, 25);
        check_frame(2);
        check_latency(3, 5, 2, 2);

        run_frame(3, 0, 1'b1, 4);
        check_frame(3);

        // Give o_data a non-zero value, then abort a frame after the 10th accept.
        run_frame(0, 0, 1'b0, 25);
        start_frame(0);
        k = 0;
        t = 0;
        while (k < 10 && t < 100) begin
            s_data  = 30'(k + 1);
            s_valid = 1'b1;
            @(negedge i_clk);
            if (m_ready) k++;
            @(posedge i_clk); #1;
            t++;
        end
        chk("abort_accepts", k, 10);
        i_rst = 1'b1;
        #1;
        chk("abort_o_data", m_data, 0);
        chk("abort_o_valid", longint'(m_valid), 0);
        chk("abort_o_last", longint'(m_last), 0);
        chk("abort_o_ready", longint'(m_ready), 0);
        chk("abort_o_busy", longint'(m_busy), 0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        repeat (10) @(posedge i_clk);
        #1;
        s_valid = 1'b0;
        chk("abort_no_valid_after", got_data.size(), 0);

        run_frame(0, 0, 1'b0, 25);
        check_frame(0);
        check_latency(3, 5, 1, 3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
